// File: rtl/wb_daq_channel_buffer.sv
// Per-channel DAQ sample buffer: packs ADC samples into bus words, queues them in a
// FIFO and drains fixed-length bursts to the SRAM arbiter via start/grant/done.
module wb_daq_channel_buffer #(
    parameter int DW     = 32,
    parameter int ADC_DW = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              wb_clk,
    input  logic              wb_rst,
    input  logic              enable,
    input  logic [1:0]        data_width,
    input  logic [ADC_DW-1:0] adc_data_in,
    input  logic              data_ready,
    input  logic [AW:0]       threshold,
    input  logic              grant,
    input  logic              data_done,
    input  logic              clear_overflow,
    output logic              sram_start,
    output logic [DW-1:0]     sram_data_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    output logic [DW-1:0]     status
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

    // Packer state
    logic [1:0]    r_lane;
    logic [DW-1:0] r_pack;

    // FIFO state
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic          r_overflow;

    // Burst FSM state
    state_t        r_state;
    logic          r_start;
    logic [DW-1:0] r_data_out;
    logic [AW:0]   r_burst;
    logic [AW:0]   r_t;

    logic [DW-1:0] w_samp;
    logic [DW-1:0] w_lane_data;
    logic [DW-1:0] w_word;
    logic          w_last;
    logic          w_complete;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW:0]   w_t_eff;

    assign w_samp = DW'(adc_data_in);

    // Place the masked sample into its lane; lanes above the current one stay zero.
    always_comb begin
        w_lane_data = '0;
        w_last      = 1'b0;
        case (data_width)
            2'd0: begin
                w_lane_data = (w_samp & DW'(32'h0000_00FF)) << {r_lane, 3'b000};
                w_last      = (r_lane == 2'd3);
            end
            2'd1: begin
                w_lane_data = (w_samp & DW'(32'h0000_FFFF)) << (r_lane[0] ? 5'd16 : 5'd0);
                w_last      = r_lane[0];
            end
            default: begin
                w_lane_data = w_samp;
                w_last      = 1'b1;
            end
        endcase
    end

    assign w_word     = r_pack | w_lane_data;
    assign w_complete = enable & data_ready & w_last;

    assign w_full  = (r_level == LP_DEPTH);
    assign w_empty = (r_level == '0);

    // Level >= T at request time guarantees every burst pop finds data.
    assign w_pop = ((r_state == ST_REQ) && grant) ||
                   ((r_state == ST_XFER) && data_done && (r_burst != r_t));
    assign w_push = w_complete && (!w_full || w_pop);

    always_comb begin
        if (threshold == '0)
            w_t_eff = LP_ONE;
        else if (threshold > LP_DEPTH)
            w_t_eff = LP_DEPTH;
        else
            w_t_eff = threshold;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (!enable) begin
            r_lane <= 2'd0;
            r_pack <= '0;
        end else if (data_ready) begin
            if (w_last) begin
                r_lane <= 2'd0;
                r_pack <= '0;
            end else begin
                r_lane <= r_lane + 2'd1;
                r_pack <= w_word;
            end
        end
    end

    always_ff @(posedge wb_clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LP_ONE;
                2'b01:   r_level <= r_level - LP_ONE;
                default: r_level <= r_level;
            endcase
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_complete && !w_push)
                r_overflow <= 1'b1;
            else if (clear_overflow)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (!wb_rst) begin
            r_state    <= ST_IDLE;
            r_start    <= 1'b0;
            r_data_out <= '0;
            r_burst    <= '0;
            r_t        <= LP_ONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_start <= 1'b0;
                    if (r_level >= w_t_eff) begin
                        r_t     <= w_t_eff;
                        r_state <= ST_REQ;
                        r_start <= 1'b1;
                    end
                end
                ST_REQ: begin
                    r_start <= 1'b1;
                    if (grant) begin
                        r_data_out <= r_mem[r_rptr];
                        r_burst    <= LP_ONE;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    r_start <= 1'b1;
                    if (data_done) begin
                        if (r_burst == r_t) begin
                            r_state <= ST_IDLE;
                            r_start <= 1'b0;
                        end else begin
                            r_data_out <= r_mem[r_rptr];
                            r_burst    <= r_burst + LP_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                end
            endcase
        end
    end

    assign sram_start    = r_start;
    assign sram_data_out = r_data_out;
    assign fifo_empty    = w_empty;
    assign fifo_full     = w_full;
    assign fifo_level    = r_level;
    assign overflow      = r_overflow;
    assign status        = DW'({r_lane, r_state, r_overflow, w_full, w_empty, 8'(r_level)});

endmodule

// File: tb/tb_wb_daq_channel_buffer.sv
// Directed bench for wb_daq_channel_buffer: packing modes, bursts, overflow,
// threshold clamping, simultaneous push/pop, reset and disable.
module tb_wb_daq_channel_buffer;

    localparam int DW     = 32;
    localparam int ADC_DW = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    logic              wb_clk = 1'b0;
    logic              wb_rst;
    logic              enable;
    logic [1:0]        data_width;
    logic [ADC_DW-1:0] adc_data_in;
    logic              data_ready;
    logic [AW:0]       threshold;
    logic              grant;
    logic              data_done;
    logic              clear_overflow;
    logic              sram_start;
    logic [DW-1:0]     sram_data_out;
    logic              fifo_empty;
    logic              fifo_full;
    logic [AW:0]       fifo_level;
    logic              overflow;
    logic [DW-1:0]     status;

    int checks = 0;
    int errors = 0;

    wb_daq_channel_buffer #(
        .DW(DW), .ADC_DW(ADC_DW), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable), .data_width(data_width),
        .adc_data_in(adc_data_in), .data_ready(data_ready), .threshold(threshold),
        .grant(grant), .data_done(data_done), .clear_overflow(clear_overflow),
        .sram_start(sram_start), .sram_data_out(sram_data_out), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .fifo_level(fifo_level), .overflow(overflow), .status(status)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] s);
        adc_data_in = s;
        data_ready  = 1'b1;
        tick();
        data_ready  = 1'b0;
    endtask

    initial begin
        wb_rst = 1'b0; enable = 1'b0; data_width = 2'd0; adc_data_in = '0;
        data_ready = 1'b0; threshold = 5'd31; grant = 1'b0; data_done = 1'b0;
        clear_overflow = 1'b0;
        tick(); tick(); tick();
        chk("rst_start", {31'd0, sram_start}, 32'd0);
        chk("rst_data", sram_data_out, 32'd0);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_status", status, 32'h100);
        wb_rst = 1'b1;
        tick();

        // Mode 0 packing
        enable = 1'b1; data_width = 2'd0;
        send(8'h11); send(8'h22);
        chk("m0_lane2_status", status, 32'h4100);
        send(8'h33); send(8'h44);
        chk("m0_level", 32'(fifo_level), 32'd1);
        chk("m0_status", status, 32'h001);
        threshold = 5'd1;
        tick();
        chk("m0_req_start", {31'd0, sram_start}, 32'd1);
        chk("m0_req_status", status, 32'h801);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("m0_word", sram_data_out, 32'h44332211);
        chk("m0_xfer_status", status, 32'h1100);
        data_done = 1'b1; tick(); data_done = 1'b0;
        chk("m0_done_start", {31'd0, sram_start}, 32'd0);

        // Mode 1 packing
        enable = 1'b0; data_width = 2'd1; tick(); enable = 1'b1;
        send(8'hAB); send(8'hCD);
        chk("m1_level", 32'(fifo_level), 32'd1);
        tick();
        grant = 1'b1; tick(); grant = 1'b0;
        chk("m1_word", sram_data_out, 32'h00CD00AB);
        data_done = 1'b1; tick(); data_done = 1'b0;

        // Mode 2 packing
        enable = 1'b0; data_width = 2'd2; tick(); enable = 1'b1;
        send(8'h7F);
        tick();
        grant = 1'b1; tick(); grant = 1'b0;
        chk("m2_word", sram_data_out, 32'h0000007F);
        data_done = 1'b1; tick(); data_done = 1'b0;
        chk("m2_idle_level", 32'(fifo_level), 32'd0);

        // Burst of four with back-to-back done
        threshold = 5'd4;
        send(8'hA0); send(8'hA1); send(8'hA2); send(8'hA3);
        chk("b4_level", 32'(fifo_level), 32'd4);
        chk("b4_start_low", {31'd0, sram_start}, 32'd0);
        tick();
        chk("b4_start_high", {31'd0, sram_start}, 32'd1);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("b4_w0", sram_data_out, 32'hA0);
        chk("b4_level_after_grant", 32'(fifo_level), 32'd3);
        data_done = 1'b1;
        tick(); chk("b4_w1", sram_data_out, 32'hA1);
        tick(); chk("b4_w2", sram_data_out, 32'hA2);
        tick(); chk("b4_w3", sram_data_out, 32'hA3);
        chk("b4_start_mid", {31'd0, sram_start}, 32'd1);
        tick(); data_done = 1'b0;
        chk("b4_start_fall", {31'd0, sram_start}, 32'd0);
        chk("b4_level_end", 32'(fifo_level), 32'd0);
        chk("b4_empty_end", {31'd0, fifo_empty}, 32'd1);

        // Overflow: 17 words into a 16-deep FIFO with no grant
        threshold = 5'd31;
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i));
        chk("ov_full16", {31'd0, fifo_full}, 32'd1);
        chk("ov_flag_before", {31'd0, overflow}, 32'd0);
        send(8'h40);
        chk("ov_flag", {31'd0, overflow}, 32'd1);
        chk("ov_level", 32'(fifo_level), 32'd16);
        chk("ov_status", status, 32'hE10);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("ov_w0", sram_data_out, 32'h30);
        data_done = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("ov_word", sram_data_out, 32'(32'h30 + i));
        end
        tick(); data_done = 1'b0;
        chk("ov_start_fall", {31'd0, sram_start}, 32'd0);
        chk("ov_level_end", 32'(fifo_level), 32'd0);
        chk("ov_flag_sticky", {31'd0, overflow}, 32'd1);
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        chk("ov_cleared", {31'd0, overflow}, 32'd0);

        // Push and pop in the same cycle
        threshold = 5'd2;
        send(8'h51); send(8'h52);
        tick();
        chk("sim_start", {31'd0, sram_start}, 32'd1);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("sim_w0", sram_data_out, 32'h51);
        chk("sim_level1", 32'(fifo_level), 32'd1);
        adc_data_in = 8'h53; data_ready = 1'b1; data_done = 1'b1;
        tick();
        data_ready = 1'b0; data_done = 1'b0;
        chk("sim_level_unchanged", 32'(fifo_level), 32'd1);
        chk("sim_w1", sram_data_out, 32'h52);
        data_done = 1'b1; tick(); data_done = 1'b0;
        chk("sim_idle_start", {31'd0, sram_start}, 32'd0);
        chk("sim_left_level", 32'(fifo_level), 32'd1);

        // Threshold 0 acts as 1
        threshold = 5'd0;
        tick();
        chk("t0_start", {31'd0, sram_start}, 32'd1);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("t0_word", sram_data_out, 32'h53);
        data_done = 1'b1; tick(); data_done = 1'b0;
        chk("t0_end_start", {31'd0, sram_start}, 32'd0);

        // Threshold above DEPTH acts as DEPTH
        threshold = 5'd31;
        for (int i = 0; i < 15; i++) send(8'(8'h60 + i));
        tick();
        chk("tbig_15_no_start", {31'd0, sram_start}, 32'd0);
        send(8'h6F);
        tick();
        chk("tbig_16_start", {31'd0, sram_start}, 32'd1);
        grant = 1'b1; tick(); grant = 1'b0;
        chk("tbig_w0", sram_data_out, 32'h60);

        // Reset in the middle of the burst
        wb_rst = 1'b0;
        tick();
        chk("mrst_start", {31'd0, sram_start}, 32'd0);
        chk("mrst_level", 32'(fifo_level), 32'd0);
        chk("mrst_status", status, 32'h100);
        chk("mrst_data", sram_data_out, 32'd0);
        wb_rst = 1'b1;
        tick();

        // Disable drops a partial word
        enable = 1'b1; data_width = 2'd0; threshold = 5'd31;
        send(8'h01); send(8'h02);
        enable = 1'b0; tick();
        chk("dis_status", status, 32'h100);
        enable = 1'b1;
        send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
        chk("dis_level", 32'(fifo_level), 32'd1);
        threshold = 5'd1;
        tick();
        grant = 1'b1; tick(); grant = 1'b0;
        chk("dis_word", sram_data_out, 32'hC4C3C2C1);
        data_done = 1'b1; tick(); data_done = 1'b0;
        chk("dis_end_start", {31'd0, sram_start}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
